// File: rtl/linebuf_window9_pkg.sv
// Shared pixel/window types for the 9x9 line-buffer producer and its innerproduct consumers.
package linebuf_pkg;
  localparam int PIX_W    = 7;
  localparam int WIN      = 9;
  localparam int WIN_AREA = WIN * WIN;

  typedef logic [PIX_W-1:0]       pix_t;
  typedef pix_t [0:WIN_AREA-1]    win_t;
  typedef pix_t [0:WIN-1]         col_t;
endpackage

// File: rtl/linebuf_window9_if.sv
// Pixel stream in, 9x9 window out. LINEBUF_COORD_EN adds the window top-left coordinates.
interface linebuf_window9_if #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
);
  import linebuf_pkg::*;

  logic pix_valid;
  logic pix_sof;
  pix_t pix_in;
  win_t xarray;
  logic win_valid;
  logic frame_done;
`ifdef LINEBUF_COORD_EN
  logic [$clog2(IMG_H)-1:0] win_row;
  logic [$clog2(IMG_W)-1:0] win_col;

  modport master (output pix_valid, pix_sof, pix_in,
                  input  xarray, win_valid, frame_done, win_row, win_col);
  modport slave  (input  pix_valid, pix_sof, pix_in,
                  output xarray, win_valid, frame_done, win_row, win_col);
`else
  modport master (output pix_valid, pix_sof, pix_in,
                  input  xarray, win_valid, frame_done);
  modport slave  (input  pix_valid, pix_sof, pix_in,
                  output xarray, win_valid, frame_done);
`endif
endinterface

// File: rtl/linebuf_window9_line_ram.sv
// One image line of pixels; combinational read returns the old word while the same address is written.
module linebuf_line_ram
  import linebuf_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rdata
);
  pix_t mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/linebuf_window9.sv
// Raster stream -> sliding 9x9 window, one window per pixel once 8 rows/cols are buffered.
// Optional LINEBUF_COORD_EN exports the top-left image coordinate of each valid window.
module linebuf_window9
  import linebuf_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic               clk,
  input  logic               reset,
  linebuf_window9_if.slave   lb
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NL = WIN - 1;

  logic          accept;
  logic [CW-1:0] col_q, cur_col;
  logic [RW-1:0] row_q, cur_row;
  logic          last_col, last_row, in_win;

  assign accept   = lb.pix_valid;
  // sof overrides the counters so a new frame always starts at (0,0)
  assign cur_col  = lb.pix_sof ? '0 : col_q;
  assign cur_row  = lb.pix_sof ? '0 : row_q;
  assign last_col = (cur_col == CW'(IMG_W - 1));
  assign last_row = (cur_row == RW'(IMG_H - 1));
  assign in_win   = (cur_row >= RW'(WIN - 1)) && (cur_col >= CW'(WIN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
    end
  end

  // Line chain: line k takes line k+1's old word, newest line takes the incoming pixel
  pix_t rd [NL];
  pix_t wd [NL];

  for (genvar k = 0; k < NL; k++) begin : g_line
    if (k == NL - 1) begin : g_top
      assign wd[k] = lb.pix_in;
    end else begin : g_mid
      assign wd[k] = rd[k+1];
    end
    linebuf_line_ram #(.DEPTH(IMG_W), .AW(CW)) u_line (
      .clk   (clk),
      .we    (accept),
      .addr  (cur_col),
      .wdata (wd[k]),
      .rdata (rd[k])
    );
  end

  col_t v;
  always_comb begin
    v = '0;
    for (int k = 0; k < NL; k++) v[k] = rd[k];
    v[WIN-1] = lb.pix_in;
  end

  win_t win_q, win_d;
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++)
        win_d[r*WIN+c] = win_q[r*WIN+c+1];
      win_d[r*WIN+WIN-1] = v[r];
    end
  end

  logic win_valid_q, frame_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (accept) win_q <= win_d;
      win_valid_q  <= accept && in_win;
      frame_done_q <= accept && last_col && last_row;
    end
  end

  assign lb.xarray     = win_q;
  assign lb.win_valid  = win_valid_q;
  assign lb.frame_done = frame_done_q;

`ifdef LINEBUF_COORD_EN
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (accept && in_win) begin
      win_row_q <= cur_row - RW'(WIN - 1);
      win_col_q <= cur_col - CW'(WIN - 1);
    end
  end

  assign lb.win_row = win_row_q;
  assign lb.win_col = win_col_q;
`endif
endmodule
